// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: conditions the front-panel buttons, prescales clk into a
// one-second tick and sequences the external BCD seconds counter one step per
// tick via a two-cycle start_stop pulse.
// Optional lap freeze of the display: define STOPWATCH_LAP_EN to build it in.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_lap,
  input  logic [3:0] cnt_h,
  input  logic [3:0] cnt_l,
  output logic       clear,
  output logic       start_stop,
  output logic       running,
  output logic [3:0] disp_h,
  output logic [3:0] disp_l,
  output logic       lap_hold
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);

  // Button 0 = start, 1 = clear, 2 = lap (lap only exists when the feature is built)
`ifdef STOPWATCH_LAP_EN
  localparam int NBTN = 3;
`else
  localparam int NBTN = 2;
`endif

  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] press;

`ifdef STOPWATCH_LAP_EN
  assign btn_raw = {btn_lap, btn_clear, btn_start};
`else
  assign btn_raw = {btn_clear, btn_start};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NBTN; gi++) begin : g_btn
      logic          sync1_q, sync2_q, level_q, press_q;
      logic [DW-1:0] db_cnt_q;

      // Synchronize, require DB_CYCLES identical samples, pulse on an accepted 0->1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_q  <= 1'b0;
          sync2_q  <= 1'b0;
          level_q  <= 1'b0;
          press_q  <= 1'b0;
          db_cnt_q <= '0;
        end else begin
          sync1_q <= btn_raw[gi];
          sync2_q <= sync1_q;
          press_q <= 1'b0;
          if (sync2_q == level_q) begin
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_LAST) begin
            level_q  <= sync2_q;
            db_cnt_q <= '0;
            press_q  <= sync2_q;
          end else begin
            db_cnt_q <= db_cnt_q + DW'(1);
          end
        end
      end

      assign press[gi] = press_q;
    end
  endgenerate

  // Same-cycle presses: clear beats start beats lap; losers are dropped
  logic clr_ev, start_ev;
  assign clr_ev   = press[1];
  assign start_ev = press[0] & ~press[1];

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP1, S_STEP2, S_PAUSE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          pend_q, pend_d;
  logic          clear_q;
  logic          counting, tick;

  assign counting = (state_q == S_RUN) || (state_q == S_STEP1) || (state_q == S_STEP2);
  assign tick     = counting && (presc_q == PRESC_LAST);

  // Next state, prescaler and pending-start; a start arriving inside a step (or
  // on a tick) is parked so the step always completes before pausing
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    pend_d  = pend_q;
    if (counting) presc_d = tick ? '0 : presc_q + PW'(1);
    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        if (start_ev) state_d = S_RUN;
      end
      S_RUN: begin
        if (tick) begin
          state_d = S_STEP1;
          if (start_ev) pend_d = 1'b1;
        end else if (start_ev || pend_q) begin
          state_d = S_PAUSE;
          pend_d  = 1'b0;
        end
      end
      S_STEP1: begin
        state_d = S_STEP2;
        if (start_ev) pend_d = 1'b1;
      end
      S_STEP2: begin
        state_d = S_RUN;
        if (start_ev) pend_d = 1'b1;
      end
      S_PAUSE: begin
        if (start_ev) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
    if (clr_ev) begin
      state_d = S_IDLE;
      presc_d = '0;
      pend_d  = 1'b0;
    end
  end

  // Sequencer state registers; clear output is the press event delayed one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      pend_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      pend_q  <= pend_d;
      clear_q <= clr_ev;
    end
  end

  assign clear      = clear_q;
  assign start_stop = (state_q == S_STEP1) || (state_q == S_STEP2);
  assign running    = counting;

`ifdef STOPWATCH_LAP_EN
  logic       lap_ev;
  logic       lap_q, lap_d;
  logic [3:0] held_h_q, held_h_d, held_l_q, held_l_d;

  assign lap_ev = press[2] & ~press[1] & ~press[0];

  // First lap press freezes the live count, the next one returns to live display
  always_comb begin
    lap_d    = lap_q;
    held_h_d = held_h_q;
    held_l_d = held_l_q;
    if (clr_ev) begin
      lap_d = 1'b0;
    end else if (lap_ev && (state_q != S_IDLE)) begin
      lap_d = ~lap_q;
      if (!lap_q) begin
        held_h_d = cnt_h;
        held_l_d = cnt_l;
      end
    end
  end

  // Lap registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_q    <= 1'b0;
      held_h_q <= 4'd0;
      held_l_q <= 4'd0;
    end else begin
      lap_q    <= lap_d;
      held_h_q <= held_h_d;
      held_l_q <= held_l_d;
    end
  end

  assign lap_hold = lap_q;
  assign disp_h   = lap_q ? held_h_q : cnt_h;
  assign disp_l   = lap_q ? held_l_q : cnt_l;
`else
  logic unused_lap;
  assign unused_lap = btn_lap;
  assign lap_hold   = 1'b0;
  assign disp_h     = cnt_h;
  assign disp_l     = cnt_l;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=10, DB_CYCLES=4 and a model of the
// BCD seconds counter attached. Honours STOPWATCH_LAP_EN like the design.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;
  localparam int TD  = 10;
  localparam int DB  = 4;
  localparam int LAT = 2 + DB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0, btn_clear = 1'b0, btn_lap = 1'b0;
  logic [3:0] cnt_h, cnt_l, disp_h, disp_l;
  logic       clear, start_stop, running, lap_hold;
  logic       cnt_flag;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // behavioural expectation: mode 0 idle / 1 run / 2 paused, step 0 none / 1 / 2
  int m_mode, m_step, m_frac, m_pend, m_clr, m_sec, m_lap, m_held;
  int q_start[$], q_clear[$], q_lap[$];
  int ss_len, exp_vec, act_vec, nsec, disp_val;
  bit sev, cev, lev, mtick;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start(btn_start), .btn_clear(btn_clear), .btn_lap(btn_lap),
    .cnt_h(cnt_h), .cnt_l(cnt_l),
    .clear(clear), .start_stop(start_stop), .running(running),
    .disp_h(disp_h), .disp_l(disp_l), .lap_hold(lap_hold)
  );

  // seconds counter: start_stop toggles its run flag, it counts while the flag is set
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_flag <= 1'b0; cnt_h <= 4'd0; cnt_l <= 4'd0;
    end else if (clear) begin
      cnt_flag <= 1'b0; cnt_h <= 4'd0; cnt_l <= 4'd0;
    end else begin
      if (start_stop) cnt_flag <= ~cnt_flag;
      if (cnt_flag) begin
        if (cnt_l == 4'd9) begin
          cnt_l <= 4'd0;
          cnt_h <= (cnt_h == 4'd5) ? 4'd0 : cnt_h + 4'd1;
        end else begin
          cnt_l <= cnt_l + 4'd1;
        end
      end
    end
  end

  function automatic int bcd(input int s);
    return ((s / 10) << 4) | (s % 10);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // per-cycle compare on the falling edge, then advance the model one cycle
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_mode = 0; m_step = 0; m_frac = 0; m_pend = 0; m_clr = 0;
        m_sec = 0; m_lap = 0; m_held = 0; ss_len = 0;
        q_start.delete(); q_clear.delete(); q_lap.delete();
      end else begin
        disp_val = m_lap ? bcd(m_held) : bcd(m_sec);
        exp_vec = (m_clr << 19) | (int'(m_step != 0) << 18) | (int'(m_mode == 1) << 17)
                | (m_lap << 16) | (disp_val << 8) | bcd(m_sec);
        act_vec = int'({clear, start_stop, running, lap_hold, disp_h, disp_l, cnt_h, cnt_l});
        check("cycle_outputs", act_vec, exp_vec);
        if (start_stop) ss_len++;
        else begin
          if (ss_len != 0 && !clear) check("start_stop_width", ss_len, 2);
          ss_len = 0;
        end
        sev = 1'b0; cev = 1'b0; lev = 1'b0;
        if (q_start.size() > 0 && q_start[0] == cyc) begin sev = 1'b1; void'(q_start.pop_front()); end
        if (q_clear.size() > 0 && q_clear[0] == cyc) begin cev = 1'b1; void'(q_clear.pop_front()); end
        if (q_lap.size() > 0 && q_lap[0] == cyc) begin lev = 1'b1; void'(q_lap.pop_front()); end
        if (cev) begin sev = 1'b0; lev = 1'b0; end
        if (sev) lev = 1'b0;
        nsec  = m_clr ? 0 : ((m_step == 2) ? (m_sec + 1) % 60 : m_sec);
        mtick = (m_mode == 1) && (m_frac == TD - 1);
        if (m_mode == 1) m_frac = (m_frac + 1) % TD;
        else if (m_mode == 0) m_frac = 0;
`ifdef STOPWATCH_LAP_EN
        if (lev && m_mode != 0) begin
          if (m_lap == 0) m_held = m_sec;
          m_lap = 1 - m_lap;
        end
`endif
        if (cev) begin
          m_mode = 0; m_step = 0; m_frac = 0; m_pend = 0; m_lap = 0;
        end else if (m_step != 0) begin
          if (sev) m_pend = 1;
          m_step = (m_step == 1) ? 2 : 0;
        end else if (m_mode == 1) begin
          if (mtick) begin
            m_step = 1;
            if (sev) m_pend = 1;
          end else if (sev || m_pend != 0) begin
            m_mode = 2; m_pend = 0;
          end
        end else if (sev) begin
          m_mode = 1;
        end
        m_clr = int'(cev);
        m_sec = nsec;
      end
      cyc = cyc + 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic go_to(input int n);
    int guard = 0;
    while (cyc < n && guard < 5000) begin @(posedge clk); #1; guard++; end
    check("schedule", cyc, n);
  endtask

  // raw press: held long enough to be accepted, event expected LAT cycles later
  task automatic press(input bit s, input bit c, input bit l);
    int ev;
    ev = cyc + LAT;
    if (s) q_start.push_back(ev);
    if (c) q_clear.push_back(ev);
    if (l) q_lap.push_back(ev);
    btn_start = s; btn_clear = c; btn_lap = l;
    repeat (DB + 2) begin @(posedge clk); #1; end
    btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
  endtask

  // wait for a plain RUN cycle at prescaler phase f (and second s when s >= 0)
  task automatic wait_frac(input int f, input int s);
    int guard = 0;
    do begin @(posedge clk); #1; guard++; end
    while (!(m_mode == 1 && m_step == 0 && m_frac == f && (s < 0 || m_sec == s)) && guard < 2000);
    if (guard >= 2000) begin
      total++; bad++;
      $display("FAIL wait_frac: timeout waiting phase %0d second %0d", f, s);
    end
  endtask

  initial begin
    int c0, c1, c2, c3, c4, c5, e, guard;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    check("reset_outputs", int'({clear, start_stop, running, lap_hold, disp_h, disp_l}), 0);

    // start and count through a full minute
    idle(4);
    c0 = cyc;
    press(1'b1, 1'b0, 1'b0);
    go_to(c0 + 6);  check("idle_before_event", int'(running), 0);
    go_to(c0 + 7);  check("run_after_event", int'(running), 1);
    go_to(c0 + 16); check("no_step_before_tick", int'(start_stop), 0);
    go_to(c0 + 17); check("step1_pulse", int'(start_stop), 1);
    go_to(c0 + 18); check("count_before_step", int'({cnt_h, cnt_l}), 8'h00);
    go_to(c0 + 19); check("first_increment", int'({cnt_h, cnt_l}), 8'h01);
    go_to(c0 + 599); check("count_59", int'({cnt_h, cnt_l}), 8'h59);
    go_to(c0 + 609); check("wrap_to_00", int'({cnt_h, cnt_l}), 8'h00);

    // pause three cycles after a tick, hold 50 cycles, resume
    idle(3);
    wait_frac(6, -1);
    c1 = cyc;
    press(1'b1, 1'b0, 1'b0);
    go_to(c1 + 6);  check("running_at_pause_event", int'(running), 1);
    go_to(c1 + 7);  check("paused", int'(running), 0);
    go_to(c1 + 51);
    c2 = cyc;
    press(1'b1, 1'b0, 1'b0);
    go_to(c2 + 6);  check("still_paused", int'(running), 0);
    go_to(c2 + 7);  check("resumed", int'(running), 1);
    go_to(c2 + 13); check("resume_no_early_step", int'(start_stop), 0);
    go_to(c2 + 14); check("resume_step1", int'(start_stop), 1);
    go_to(c2 + 15); check("resume_step2", int'(start_stop), 1);
    go_to(c2 + 16); check("resume_step_done", int'(start_stop), 0);

    // start press landing in STEP1
    idle(8);
    wait_frac(4, -1);
    c3 = cyc;
    press(1'b1, 1'b0, 1'b0);
    e = c3 + 6;
    go_to(e);     check("pend_step1", int'(start_stop), 1);
    go_to(e + 1); check("pend_step2", int'(start_stop), 1);
    go_to(e + 2); check("pend_back_in_run", int'({running, start_stop}), 2'b10);
    go_to(e + 3); check("pend_paused", int'(running), 0);

    // resume, then clear landing in STEP2
    idle(8);
    press(1'b1, 1'b0, 1'b0);
    idle(8);
    wait_frac(5, -1);
    c4 = cyc;
    press(1'b0, 1'b1, 1'b0);
    e = c4 + 6;
    go_to(e + 1); check("clear_pulse", int'({clear, running, start_stop}), 3'b100);
    go_to(e + 2); check("clear_done", int'({clear, cnt_h, cnt_l}), 0);
    idle(40);
    check("no_stray_increment", int'({cnt_h, cnt_l}), 8'h00);

    // lap at 12, second lap at 15
    press(1'b1, 1'b0, 1'b0);
    wait_frac(3, 12);
    press(1'b0, 1'b0, 1'b1);
    wait_frac(3, 15);
`ifdef STOPWATCH_LAP_EN
    check("lap_frozen", int'({lap_hold, disp_h, disp_l}), 9'h112);
`else
    check("lap_absent", int'({lap_hold, disp_h, disp_l}), 9'h015);
`endif
    c5 = cyc;
    press(1'b0, 1'b0, 1'b1);
    go_to(c5 + 8);
    check("lap_released_live", int'({lap_hold, disp_h, disp_l}), 9'h015);

    // simultaneous clear and start while running
    idle(8);
    c5 = cyc;
    press(1'b1, 1'b1, 1'b0);
    go_to(c5 + 7); check("collide_clear", int'({clear, running}), 2'b10);
    go_to(c5 + 9); check("collide_idle", int'({running, cnt_h, cnt_l}), 0);

    // asynchronous reset in the middle of STEP1
    idle(8);
    press(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (m_step != 1 && guard < 200) begin @(posedge clk); #1; guard++; end
    check("reached_step1", int'(start_stop), 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", int'({clear, start_stop, running, lap_hold, disp_h, disp_l}), 0);
    idle(3);
    rst_n = 1'b1;
    idle(20);
    check("after_reset_idle", int'({running, start_stop, cnt_h, cnt_l}), 0);

    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
